// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states and master indices for the memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANTED, WAIT_D} state_t;
    localparam int M_IF = 0;
    localparam int M_MA = 1;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IF/MA) single-slave arbiter with per-master bus lock
// and a hold counter that bounds how long a locked owner can starve the other.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 64,
    parameter int DW       = 64,
    parameter int HOLD_MAX = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              m_request,
    input  logic [1:0]              m_a_valid,
    output logic [1:0]              m_a_ready,
    input  logic [1:0][2:0]         m_a_opcode,
    input  logic [1:0][AW-1:0]      m_a_address,
    input  logic [1:0][DW-1:0]      m_a_data,
    input  logic [1:0][DW/8-1:0]    m_a_mask,
    input  logic [1:0][2:0]         m_a_size,
    output logic [1:0]              m_d_valid,
    input  logic [1:0]              m_d_ready,
    output logic [DW-1:0]           m_d_data,
    output logic                    m_d_error,
    output logic                    s_a_valid,
    input  logic                    s_a_ready,
    output logic [2:0]              s_a_opcode,
    output logic [AW-1:0]           s_a_address,
    output logic [DW-1:0]           s_a_data,
    output logic [DW/8-1:0]         s_a_mask,
    output logic [2:0]              s_a_size,
    input  logic                    s_d_valid,
    output logic                    s_d_ready,
    input  logic [DW-1:0]           s_d_data,
    input  logic                    s_d_error,
    output logic [1:0]              grant
);
    localparam int CW = ($clog2(HOLD_MAX + 1) < 4) ? 4 : $clog2(HOLD_MAX + 1);

    state_t        state, state_n;
    logic [1:0]    grant_n, cand;
    logic          last, last_n, own, win, expired, in_g, in_w;
    logic [CW-1:0] cnt, cnt_n;

    assign own     = grant[M_MA];
    assign cand    = m_a_valid | m_request;
    assign win     = (&cand) ? ~last : cand[M_MA];
    assign expired = cnt == CW'(HOLD_MAX);
    assign in_g    = state == GRANTED;
    assign in_w    = state == WAIT_D;

    // Expiry blocks a new A issue but never cuts an outstanding transaction.
    assign s_a_valid   = in_g & ~expired & m_a_valid[own];
    assign m_a_ready   = {2{in_g & ~expired & s_a_ready}} & grant;
    assign s_d_ready   = in_w & m_d_ready[own];
    assign m_d_valid   = {2{in_w & s_d_valid}} & grant;
    assign m_d_data    = s_d_data;
    assign m_d_error   = s_d_error;
    assign s_a_opcode  = m_a_opcode[own];
    assign s_a_address = m_a_address[own];
    assign s_a_data    = m_a_data[own];
    assign s_a_mask    = m_a_mask[own];
    assign s_a_size    = m_a_size[own];

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        cnt_n   = (state != IDLE && cand[~own] && !expired) ? cnt + CW'(1) : cnt;
        case (state)
            IDLE: if (|cand) begin
                state_n = GRANTED;
                grant_n = win ? 2'b10 : 2'b01;
                cnt_n   = '0;
            end
            GRANTED: if (s_a_valid && s_a_ready) begin
                state_n = WAIT_D;
            end else if (expired || !cand[own]) begin
                state_n = IDLE;
                grant_n = '0;
                last_n  = own;
            end
            WAIT_D: if (s_d_valid && s_d_ready) begin
                state_n = (m_request[own] && !expired) ? GRANTED : IDLE;
                grant_n = (m_request[own] && !expired) ? grant : 2'b00;
                last_n  = (m_request[own] && !expired) ? last : own;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant, lock, starvation release, reset and back-pressure.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           m_request = '0;
    logic [1:0]           m_a_valid = '0;
    logic [1:0]           m_a_ready;
    logic [1:0][2:0]      m_a_opcode = '0;
    logic [1:0][AW-1:0]   m_a_address = '0;
    logic [1:0][DW-1:0]   m_a_data = '0;
    logic [1:0][DW/8-1:0] m_a_mask = '0;
    logic [1:0][2:0]      m_a_size = '0;
    logic [1:0]           m_d_valid;
    logic [1:0]           m_d_ready = '0;
    logic [DW-1:0]        m_d_data;
    logic                 m_d_error;
    logic                 s_a_valid;
    logic                 s_a_ready = 1'b0;
    logic [2:0]           s_a_opcode;
    logic [AW-1:0]        s_a_address;
    logic [DW-1:0]        s_a_data;
    logic [DW/8-1:0]      s_a_mask;
    logic [2:0]           s_a_size;
    logic                 s_d_valid = 1'b0;
    logic                 s_d_ready;
    logic [DW-1:0]        s_d_data = '0;
    logic                 s_d_error = 1'b0;
    logic [1:0]           grant;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m_request(m_request), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
        .m_a_opcode(m_a_opcode), .m_a_address(m_a_address), .m_a_data(m_a_data),
        .m_a_mask(m_a_mask), .m_a_size(m_a_size),
        .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_data(m_d_data), .m_d_error(m_d_error),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_address(s_a_address), .s_a_data(s_a_data), .s_a_mask(s_a_mask), .s_a_size(s_a_size),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_data(s_d_data), .s_d_error(s_d_error),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #12;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_a_valid", s_a_valid, 1'b0);
        chk("rst_s_d_ready", s_d_ready, 1'b0);
        chk("rst_m_a_ready", m_a_ready, 2'b00);
        chk("rst_m_d_valid", m_d_valid, 2'b00);
        rst = 1'b0;

        // single IF read
        m_a_valid = 2'b01; m_a_address[0] = 64'h8000_0000; m_a_opcode[0] = 3'd4; m_a_size[0] = 3'd3;
        s_a_ready = 1'b1; m_d_ready = 2'b11;
        tick;
        chk("if_grant", grant, 2'b01);
        chk("if_s_a_valid", s_a_valid, 1'b1);
        chk("if_s_a_address", s_a_address, 64'h8000_0000);
        chk("if_s_a_opcode", s_a_opcode, 3'd4);
        chk("if_m_a_ready", m_a_ready, 2'b01);
        tick;
        m_a_valid = 2'b00; #1;
        chk("if_wait_s_a_valid", s_a_valid, 1'b0);
        chk("if_wait_m_d_valid", m_d_valid, 2'b00);
        chk("if_wait_s_d_ready", s_d_ready, 1'b1);
        tick;
        chk("if_wait2_m_d_valid", m_d_valid, 2'b00);
        s_d_valid = 1'b1; s_d_data = 64'h13; #1;
        chk("if_d_valid", m_d_valid, 2'b01);
        chk("if_d_data", m_d_data, 64'h13);
        tick;
        s_d_valid = 1'b0; #1;
        chk("if_release", grant, 2'b00);

        // tie: MA first, then IF, then MA again
        m_a_valid = 2'b11; m_a_address[1] = 64'h100; #1;
        tick;
        chk("tie1_grant", grant, 2'b10);
        chk("tie1_s_a_address", s_a_address, 64'h100);
        chk("tie1_m_a_ready", m_a_ready, 2'b10);
        tick;
        m_a_valid = 2'b01; s_d_valid = 1'b1; #1;
        chk("tie1_m_d_valid", m_d_valid, 2'b10);
        tick;
        s_d_valid = 1'b0; #1;
        chk("tie1_release", grant, 2'b00);
        tick;
        chk("tie1_if_grant", grant, 2'b01);
        tick;
        m_a_valid = 2'b00; s_d_valid = 1'b1; #1;
        chk("tie1_if_m_d_valid", m_d_valid, 2'b01);
        tick;
        s_d_valid = 1'b0; m_a_valid = 2'b11; #1;
        tick;
        chk("tie2_grant", grant, 2'b10);
        tick;
        m_a_valid = 2'b00; s_d_valid = 1'b1;
        tick;
        s_d_valid = 1'b0; #1;
        chk("tie2_release", grant, 2'b00);

        // MA lock across three writes
        m_request = 2'b10; m_a_valid = 2'b10; m_a_opcode[1] = 3'd0; s_d_valid = 1'b1; #1;
        tick;
        for (int w = 0; w < 3; w++) begin
            chk("lock_grant_a", grant, 2'b10);
            chk("lock_s_a_valid", s_a_valid, 1'b1);
            tick;
            chk("lock_grant_d", grant, 2'b10);
            chk("lock_m_d_valid", m_d_valid, 2'b10);
            if (w == 2) begin
                m_request = 2'b00; m_a_valid = 2'b00; #1;
            end
            tick;
        end
        chk("lock_release", grant, 2'b00);

        // starvation: MA locked, IF waiting, HOLD_MAX = 4
        m_request = 2'b10; m_a_valid = 2'b10; #1;
        tick;
        chk("starve_grant", grant, 2'b10);
        tick;
        m_a_valid = 2'b11; #1;
        chk("starve_nonowner_ready", m_a_ready, 2'b00);
        chk("starve_d0", m_d_valid, 2'b10);
        tick;
        chk("starve_g1", grant, 2'b10);
        chk("starve_a1", s_a_valid, 1'b1);
        tick;
        tick;
        chk("starve_a2", s_a_valid, 1'b1);
        tick;
        chk("starve_last_d", m_d_valid, 2'b10);
        tick;
        chk("starve_release", grant, 2'b00);
        tick;
        chk("starve_if_grant", grant, 2'b01);
        chk("starve_if_m_a_ready", m_a_ready, 2'b01);
        m_request = 2'b00; m_a_valid = 2'b01; #1;
        tick;
        m_a_valid = 2'b00;
        tick;
        s_d_valid = 1'b0; #1;
        chk("starve_if_release", grant, 2'b00);

        // asynchronous reset while waiting for D
        m_a_valid = 2'b01; #1;
        tick;
        tick;
        m_a_valid = 2'b00; #1;
        chk("rst_mid_s_d_ready_pre", s_d_ready, 1'b1);
        #2;
        rst = 1'b1; s_d_valid = 1'b1; #1;
        chk("rst_mid_grant", grant, 2'b00);
        chk("rst_mid_s_d_ready", s_d_ready, 1'b0);
        chk("rst_mid_m_d_valid", m_d_valid, 2'b00);
        chk("rst_mid_s_a_valid", s_a_valid, 1'b0);
        chk("rst_mid_m_a_ready", m_a_ready, 2'b00);
        rst = 1'b0; s_d_valid = 1'b0; m_a_valid = 2'b01;
        tick;
        chk("rst_after_grant", grant, 2'b01);
        tick;
        m_a_valid = 2'b00; s_d_valid = 1'b1;
        tick;
        s_d_valid = 1'b0;

        // back-pressure on A
        m_a_valid = 2'b10; s_a_ready = 1'b0;
        m_a_address[1] = 64'h1234; m_a_data[1] = 64'hdead_beef; m_a_mask[1] = 8'hff; #1;
        tick;
        chk("bp_grant", grant, 2'b10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_s_a_valid", s_a_valid, 1'b1);
            chk("bp_s_a_address", s_a_address, 64'h1234);
            chk("bp_s_a_data", s_a_data, 64'hdead_beef);
            chk("bp_s_a_mask", s_a_mask, 8'hff);
            chk("bp_m_a_ready", m_a_ready, 2'b00);
            chk("bp_m_d_valid", m_d_valid, 2'b00);
            tick;
        end
        s_a_ready = 1'b1; #1;
        chk("bp_m_a_ready_go", m_a_ready, 2'b10);
        tick;
        m_a_valid = 2'b00; s_d_valid = 1'b1; s_d_error = 1'b1; #1;
        chk("bp_m_d_error", m_d_error, 1'b1);
        chk("bp_m_d_valid_go", m_d_valid, 2'b10);
        tick;
        s_d_valid = 1'b0; s_d_error = 1'b0; #1;
        chk("bp_release", grant, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
